// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong sound/channel codes, FSM states and counter widths
package pong_pkg;

  // Sound request codes; 0 is handled as ping by the sound block
  localparam logic [1:0] SND_PING = 2'd1;
  localparam logic [1:0] SND_PONG = 2'd2;
  localparam logic [1:0] SND_GOAL = 2'd3;

  // Channel request codes; bit 1 drives the left speaker, bit 0 the right
  localparam logic [1:0] CH_NONE  = 2'd0;
  localparam logic [1:0] CH_RIGHT = 2'd1;
  localparam logic [1:0] CH_LEFT  = 2'd2;
  localparam logic [1:0] CH_BOTH  = 2'd3;

  localparam int CNT_W  = 24;
  localparam int STEP_W = 23;

  typedef enum logic [2:0] {IDLE, TONE, GOAL_HI, GOAL_LO, WAIT} state_t;

  // Half-period of a tone in clock cycles, truncated
  function automatic logic [CNT_W-1:0] half_period(input int clk_freq, input int hz);
    return CNT_W'(clk_freq / (2 * hz));
  endfunction

endpackage

// File: rtl/pong_sound_sync.sv
// rtl/pong_sound_sync.sv - three-stage bus synchronizer with a stability flag
module pong_sound_sync
  import pong_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         stable
);

  logic [W-1:0] s1, s2, s3;

  // Two metastability flops followed by a compare stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A torn multi-bit value never survives two consecutive samples
  assign stable = (s2 == s3);
  assign q      = s3;

endmodule

// File: rtl/pong_sound.sv
// rtl/pong_sound.sv - Pong audio back-end: request sync, tone FSM, speaker drive
module pong_sound
  import pong_pkg::*;
#(
  parameter int CLK_FREQ         = 40_000_000,
  parameter int PING_HZ          = 880,
  parameter int PONG_HZ          = 440,
  parameter int GOAL_HI_HZ       = 523,
  parameter int GOAL_LO_HZ       = 262,
  parameter int GOAL_STEP_CYCLES = 4_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] channel,
  input  logic [1:0] sound,
  input  logic       mute,
  output logic       spk_left,
  output logic       spk_right,
  output logic       busy
);

  localparam logic [CNT_W-1:0]  HALF_PING    = half_period(CLK_FREQ, PING_HZ);
  localparam logic [CNT_W-1:0]  HALF_PONG    = half_period(CLK_FREQ, PONG_HZ);
  localparam logic [CNT_W-1:0]  HALF_GOAL_HI = half_period(CLK_FREQ, GOAL_HI_HZ);
  localparam logic [CNT_W-1:0]  HALF_GOAL_LO = half_period(CLK_FREQ, GOAL_LO_HZ);
  localparam logic [STEP_W-1:0] STEP_LAST    = STEP_W'(GOAL_STEP_CYCLES - 1);

  logic [3:0]        req;
  logic              req_stable;
  logic [1:0]        req_ch, req_snd;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, half;
  logic [STEP_W-1:0] step, step_n;
  logic              wave, wave_n;
  logic [1:0]        ch_q, ch_n, snd_q, snd_n;
  logic              tick_wrap;

  pong_sound_sync #(.W(4)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d      ({channel, sound}),
    .q      (req),
    .stable (req_stable)
  );

  assign req_ch  = req[3:2];
  assign req_snd = req[1:0];

  // Next-state, wave and latch logic; the counter and wave restart on every note entry
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    step_n  = step;
    wave_n  = wave;
    ch_n    = ch_q;
    snd_n   = snd_q;

    case (state)
      TONE:    half = (snd_q == SND_PONG) ? HALF_PONG : HALF_PING;
      GOAL_HI: half = HALF_GOAL_HI;
      GOAL_LO: half = HALF_GOAL_LO;
      default: half = HALF_PING;
    endcase
    tick_wrap = (cnt == half - CNT_W'(1));

    case (state)
      IDLE: begin
        wave_n = 1'b0;
        cnt_n  = '0;
        step_n = '0;
        if (req_stable && req_ch != CH_NONE) begin
          ch_n    = req_ch;
          snd_n   = req_snd;
          state_n = (req_snd == SND_GOAL) ? GOAL_HI : TONE;
        end
      end
      TONE: begin
        if (req_stable && req_ch == CH_NONE) begin
          state_n = IDLE;
          wave_n  = 1'b0;
          cnt_n   = '0;
        end else if (req_stable && {req_ch, req_snd} != {ch_q, snd_q}) begin
          ch_n    = req_ch;
          snd_n   = req_snd;
          cnt_n   = '0;
          step_n  = '0;
          wave_n  = 1'b0;
          state_n = (req_snd == SND_GOAL) ? GOAL_HI : TONE;
        end else if (tick_wrap) begin
          cnt_n  = '0;
          wave_n = ~wave;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      GOAL_HI, GOAL_LO: begin
        if (step == STEP_LAST) begin
          step_n  = '0;
          cnt_n   = '0;
          wave_n  = 1'b0;
          state_n = (state == GOAL_HI) ? GOAL_LO : WAIT;
        end else begin
          step_n = step + STEP_W'(1);
          if (tick_wrap) begin
            cnt_n  = '0;
            wave_n = ~wave;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        wave_n = 1'b0;
        cnt_n  = '0;
        step_n = '0;
        if (req_stable && req_ch == CH_NONE) state_n = IDLE;
      end
    endcase
  end

  // State register; speakers are registered from next-state values so they track wave directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      step      <= '0;
      wave      <= 1'b0;
      ch_q      <= '0;
      snd_q     <= '0;
      spk_left  <= 1'b0;
      spk_right <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      step      <= step_n;
      wave      <= wave_n;
      ch_q      <= ch_n;
      snd_q     <= snd_n;
      spk_left  <= wave_n & ch_n[1] & ~mute;
      spk_right <= wave_n & ch_n[0] & ~mute;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pong_sound.sv
// tb/tb_pong_sound.sv - randomized self-checking bench for pong_sound
module tb_pong_sound;

  localparam int STEP    = 40;
  localparam int H_PING  = 1000 / (2 * 100);
  localparam int H_PONG  = 1000 / (2 * 50);
  localparam int H_GHI   = 1000 / (2 * 125);
  localparam int H_GLO   = 1000 / (2 * 50);
  localparam int M_IDLE  = 0;
  localparam int M_TONE  = 1;
  localparam int M_GOAL  = 2;
  localparam int M_WAIT  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] channel = 2'd0;
  logic [1:0] sound = 2'd0;
  logic       mute = 1'b0;
  logic       spk_left, spk_right, busy;

  int checks = 0;
  int failures = 0;

  pong_sound #(
    .CLK_FREQ(1000), .PING_HZ(100), .PONG_HZ(50),
    .GOAL_HI_HZ(125), .GOAL_LO_HZ(50), .GOAL_STEP_CYCLES(STEP)
  ) dut (
    .clk(clk), .reset(reset), .channel(channel), .sound(sound), .mute(mute),
    .spk_left(spk_left), .spk_right(spk_right), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: segment start time plus arithmetic on elapsed cycles
  int         m_mode = M_IDLE;
  int         m_t0 = 0;
  int         n_edge = 0;
  logic [3:0] h1 = '0, h2 = '0, h3 = '0, m_lat = '0;
  logic       exp_l = 1'b0, exp_r = 1'b0, exp_busy = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode   <= M_IDLE;
      m_t0     <= 0;
      n_edge   <= 0;
      h1       <= '0;
      h2       <= '0;
      h3       <= '0;
      m_lat    <= '0;
      exp_l    <= 1'b0;
      exp_r    <= 1'b0;
      exp_busy <= 1'b0;
    end else begin : model_step
      logic [3:0] req, lat;
      logic       st, w;
      int         mode, t0, k;
      req  = h3;
      st   = (h2 == h3);
      mode = m_mode;
      t0   = m_t0;
      lat  = m_lat;
      case (mode)
        M_IDLE: if (st && req[3:2] != 2'd0) begin
          lat = req; t0 = n_edge; mode = (req[1:0] == 2'd3) ? M_GOAL : M_TONE;
        end
        M_TONE: if (st && req[3:2] == 2'd0) mode = M_IDLE;
                else if (st && req != lat) begin
                  lat = req; t0 = n_edge; mode = (req[1:0] == 2'd3) ? M_GOAL : M_TONE;
                end
        M_GOAL: if (n_edge - t0 >= 2 * STEP) mode = M_WAIT;
        default: if (st && req[3:2] == 2'd0) mode = M_IDLE;
      endcase
      k = n_edge - t0;
      w = 1'b0;
      if (mode == M_TONE)
        w = ((k / ((lat[1:0] == 2'd2) ? H_PONG : H_PING)) % 2) == 1;
      else if (mode == M_GOAL)
        w = (k < STEP) ? (((k / H_GHI) % 2) == 1) : ((((k - STEP) / H_GLO) % 2) == 1);
      exp_l    <= w & lat[3] & ~mute;
      exp_r    <= w & lat[2] & ~mute;
      exp_busy <= (mode != M_IDLE);
      m_mode   <= mode;
      m_t0     <= t0;
      m_lat    <= lat;
      n_edge   <= n_edge + 1;
      h3       <= h2;
      h2       <= h1;
      h1       <= {channel, sound};
    end
  end

  always @(negedge clk) begin
    check_eq("busy", busy, exp_busy);
    check_eq("spk_left", spk_left, exp_l);
    check_eq("spk_right", spk_right, exp_r);
  end

  task automatic drive(input logic [1:0] c, input logic [1:0] s, input logic m, input int n);
    @(negedge clk);
    channel = c;
    sound   = s;
    mute    = m;
    repeat (n) @(posedge clk);
  endtask

  task automatic async_reset(input int dly);
    @(posedge clk);
    #(dly);
    reset = 1'b1;
    #1;
    check_eq("rst_left", spk_left, 0);
    check_eq("rst_right", spk_right, 0);
    check_eq("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Ping on both speakers: latency and first-high timing
    @(negedge clk);
    channel = 2'd3; sound = 2'd1;
    repeat (3) @(posedge clk); #1;
    check_eq("lat_busy_e2", busy, 0);
    @(posedge clk); #1;
    check_eq("lat_busy_e3", busy, 1);
    repeat (4) @(posedge clk); #1;
    check_eq("first_hi_e7", spk_left, 0);
    @(posedge clk); #1;
    check_eq("first_hi_e8_l", spk_left, 1);
    check_eq("first_hi_e8_r", spk_right, 1);
    drive(2'd3, 2'd1, 1'b0, 20);
    drive(2'd0, 2'd1, 1'b0, 10);

    // Reset in the middle of a tone, then idle after release
    drive(2'd3, 2'd2, 1'b0, 23);
    async_reset(2);
    @(posedge clk); #1;
    check_eq("post_rst_idle", busy, 0);
    drive(2'd0, 2'd0, 1'b0, 10);

    // Left pong, then switch to right ping
    drive(2'd2, 2'd2, 1'b0, 60);
    drive(2'd1, 2'd1, 1'b0, 40);
    drive(2'd0, 2'd0, 1'b0, 10);

    // Goal held: full jingle then WAIT until released
    drive(2'd2, 2'd3, 1'b0, 200);
    #1;
    check_eq("wait_busy", busy, 1);
    check_eq("wait_left", spk_left, 0);
    @(negedge clk);
    channel = 2'd0;
    repeat (3) @(posedge clk); #1;
    check_eq("release_e2", busy, 1);
    @(posedge clk); #1;
    check_eq("release_e3", busy, 0);

    // Goal withdrawn early still plays the whole jingle
    drive(2'd3, 2'd3, 1'b0, 10);
    drive(2'd0, 2'd0, 1'b0, 100);

    // Mute during ping
    drive(2'd3, 2'd1, 1'b0, 23);
    drive(2'd3, 2'd1, 1'b1, 17);
    drive(2'd3, 2'd1, 1'b0, 20);
    drive(2'd0, 2'd1, 1'b0, 10);

    // Random request streams with occasional asynchronous resets
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 24) == 0)
        async_reset(int'($urandom_range(1, 8)));
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), int'($urandom_range(1, 100)));
    end
    drive(2'd0, 2'd0, 1'b0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
